// File: rtl/q2_sequencer.sv
// q2_sequencer -- Q2 control unit.
// Owns the instruction-cycle state register, the two-phase (setup/write) bus
// timing with memory wait states and a wait timeout, the bit-serial ALU
// counter and the front-panel run/step/deposit handling. All datapath
// strobes are decoded from the registered state so they are quiet in reset.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_op[3:0]             op5..op2 from the instruction register
//   i_f, i_dbus_msb, i_x0, i_alu_cout   datapath status inputs
//   i_mem_ready           memory ready, qualifies the setup phase
//   i_run, i_step, i_dep_sw   front-panel controls (step/deposit edge-detected)
//   o_state, o_phase, o_bit_cnt   sequencer state
//   o_rd*, o_wr*, o_incp_clk      bus read selects and write strobes
//   o_xhin_*, o_xlin_*            X register input mux selects
//   o_fout, o_halted, o_bus_err   next flag, halt indicator, sticky bus error
module q2_sequencer #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 3,
    parameter int WAIT_LIMIT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_op,
    input  logic             i_f,
    input  logic             i_dbus_msb,
    input  logic             i_x0,
    input  logic             i_alu_cout,
    input  logic             i_mem_ready,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_dep_sw,
    output logic [2:0]       o_state,
    output logic             o_phase,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic             o_rdp,
    output logic             o_rdx,
    output logic             o_rda,
    output logic             o_rdm,
    output logic             o_wro,
    output logic             o_wra,
    output logic             o_wrx,
    output logic             o_wrp,
    output logic             o_wrm,
    output logic             o_wrf,
    output logic             o_incp_clk,
    output logic             o_xhin_shift,
    output logic             o_xhin_p,
    output logic             o_xhin_zero,
    output logic             o_xhin_dbus,
    output logic             o_xlin_shift,
    output logic             o_xlin_dbus,
    output logic             o_fout,
    output logic             o_halted,
    output logic             o_bus_err
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_LOAD  = 3'd1,
        S_DEREF = 3'd2,
        S_EXEC  = 3'd3,
        S_ALU   = 3'd4,
        S_HALT  = 3'd7
    } state_t;

    localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_LIMIT > 0) ? (WAIT_LIMIT - 1) : 0);
    localparam logic              WAIT_EN   = (WAIT_LIMIT > 0);

    state_t            r_state, w_state_nxt, w_bnd_state;
    logic              r_phase, w_phase_nxt;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_nxt;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic              r_bus_err, w_err_nxt;
    logic              r_single, w_single_nxt;
    logic              r_step_q, r_dep_q, r_dep_pulse;
    logic              w_step_rise, w_dep_rise;
    logic              w_op5, w_op4, w_op3, w_op2, w_alu_class;
    logic              w_fe, w_ld, w_dr, w_ex, w_al, w_ws;

    assign w_op5       = i_op[3];
    assign w_op4       = i_op[2];
    assign w_op3       = i_op[1];
    assign w_op2       = i_op[0];
    assign w_alu_class = (~w_op3 & ~w_op4) | ~w_op5;
    assign w_step_rise = i_step & ~r_step_q;
    assign w_dep_rise  = i_dep_sw & ~r_dep_q;
    // A single-stepped instruction always stops at its boundary, even if run rose meanwhile.
    assign w_bnd_state = (i_run && !r_single) ? S_FETCH : S_HALT;

    // Next-state logic for the instruction cycle, bus phase, ALU and wait counters.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_bit_nxt    = r_bit_cnt;
        w_wait_nxt   = r_wait;
        w_err_nxt    = r_bus_err;
        w_single_nxt = r_single;
        case (r_state)
            S_HALT: begin
                if (i_run) begin
                    w_state_nxt  = S_FETCH;
                    w_err_nxt    = 1'b0;
                    w_single_nxt = 1'b0;
                end else if (w_step_rise) begin
                    w_state_nxt  = S_FETCH;
                    w_err_nxt    = 1'b0;
                    w_single_nxt = 1'b1;
                end else begin
                    w_state_nxt  = S_HALT;
                end
            end
            S_FETCH, S_LOAD, S_DEREF, S_EXEC: begin
                if (!r_phase) begin
                    if (i_mem_ready) begin
                        w_phase_nxt = 1'b1;
                        w_wait_nxt  = {WAIT_W{1'b0}};
                    end else if (WAIT_EN && (r_wait == WAIT_LAST)) begin
                        // Timeout: abandon the cycle before any write strobe fires.
                        w_err_nxt    = 1'b1;
                        w_state_nxt  = S_HALT;
                        w_wait_nxt   = {WAIT_W{1'b0}};
                        w_single_nxt = 1'b0;
                    end else begin
                        w_wait_nxt = r_wait + WAIT_W'(1);
                    end
                end else begin
                    w_phase_nxt = 1'b0;
                    case (r_state)
                        S_FETCH: w_state_nxt = w_op5 ? S_EXEC : S_LOAD;
                        S_LOAD:  w_state_nxt = w_op2 ? S_DEREF : S_EXEC;
                        S_DEREF: w_state_nxt = S_EXEC;
                        default: begin
                            if (w_alu_class) begin
                                w_state_nxt = S_ALU;
                            end else begin
                                w_state_nxt  = w_bnd_state;
                                w_single_nxt = 1'b0;
                            end
                        end
                    endcase
                end
            end
            S_ALU: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_bit_nxt    = {CNT_W{1'b0}};
                    w_state_nxt  = w_bnd_state;
                    w_single_nxt = 1'b0;
                end else begin
                    w_bit_nxt = r_bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                // Unused encodings recover to a safe halt.
                w_state_nxt = S_HALT;
                w_phase_nxt = 1'b0;
                w_bit_nxt   = {CNT_W{1'b0}};
                w_wait_nxt  = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Sequencer state registers, front-panel edge detectors and deposit pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_HALT;
            r_phase     <= 1'b0;
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_wait      <= {WAIT_W{1'b0}};
            r_bus_err   <= 1'b0;
            r_single    <= 1'b0;
            r_step_q    <= 1'b0;
            r_dep_q     <= 1'b0;
            r_dep_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_wait      <= w_wait_nxt;
            r_bus_err   <= w_err_nxt;
            r_single    <= w_single_nxt;
            r_step_q    <= i_step;
            r_dep_q     <= i_dep_sw;
            // Registered so the deposit strobe is a clean single-cycle pulse.
            r_dep_pulse <= (r_state == S_HALT) & w_dep_rise;
        end
    end

    assign w_fe = (r_state == S_FETCH);
    assign w_ld = (r_state == S_LOAD);
    assign w_dr = (r_state == S_DEREF);
    assign w_ex = (r_state == S_EXEC);
    assign w_al = (r_state == S_ALU);
    // Write strobes fire in the write phase of a memory cycle and on every ALU cycle.
    assign w_ws = w_al | ((w_fe | w_ld | w_dr | w_ex) & r_phase);

    assign o_state      = r_state;
    assign o_phase      = r_phase;
    assign o_bit_cnt    = r_bit_cnt;
    assign o_halted     = (r_state == S_HALT);
    assign o_bus_err    = r_bus_err;
    assign o_rdp        = w_fe;
    assign o_rdx        = ~w_fe;
    assign o_rda        = w_ex;
    assign o_rdm        = ~w_ex;
    assign o_wro        = w_fe & w_ws;
    assign o_wra        = w_al & w_ws;
    assign o_wrx        = (w_al | w_dr | w_ld | w_fe) & w_ws;
    assign o_wrp        = w_ex & w_op5 & w_op4 & (~w_op3 | ~i_f) & w_ws;
    assign o_incp_clk   = (w_fe & w_ws) | r_dep_pulse;
    assign o_wrm        = (w_ex & w_op5 & ~w_op4 & w_op3 & w_ws) | r_dep_pulse;
    assign o_wrf        = (w_al | (w_ex & ~w_op5)) & w_ws;
    assign o_xhin_shift = w_al;
    assign o_xlin_shift = w_al;
    assign o_xhin_p     = w_fe & ~i_dbus_msb;
    assign o_xhin_zero  = w_fe & i_dbus_msb;
    assign o_xhin_dbus  = w_ld | w_dr;
    assign o_xlin_dbus  = ~w_al;
    assign o_fout       = (w_al & i_alu_cout) | (w_ex & (~w_op4 | (w_op3 & i_x0)));

endmodule

// File: doc/q2_sequencer.md
Name: q2_sequencer

Overview:
Parametrised next-generation Q2 control unit. It owns the instruction-cycle state register, a two-phase (setup/write) bus timing generator with memory wait states, a WIDTH-cycle bit-serial ALU counter, and front-panel run/step/deposit handling. It drives every register/bus strobe of the Q2 datapath and replaces the externally supplied state bits and write strobe.

Parameters:
WIDTH, 8, datapath word width; number of bit-serial ALU cycles per ALU instruction.
CNT_W, 3, width of bit counter; must satisfy 2**CNT_W >= WIDTH.
WAIT_LIMIT, 15, max setup-phase wait cycles before bus error; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
op  in  4  opcode bits op[3:0] = Q2 op5..op2 from instruction register
f  in  1  flag register value
dbus_msb  in  1  data bus bit WIDTH-1
x0  in  1  X register bit 0
alu_cout  in  1  ALU carry out
mem_ready  in  1  memory ready; qualifies setup phase
run  in  1  front-panel run level
step  in  1  front-panel step (level, edge-detected internally)
dep_sw  in  1  front-panel deposit (level, edge-detected internally)
state  out  3  0 FETCH, 1 LOAD, 2 DEREF, 3 EXEC, 4 ALU, 7 HALT
phase  out  1  0 setup, 1 write
bit_cnt  out  CNT_W  ALU bit index
rdp, rdx, rda, rdm  out  1 each  bus read selects
wro, wra, wrx, wrp, wrm, wrf, incp_clk  out  1 each  write strobes
xhin_shift, xhin_p, xhin_zero, xhin_dbus, xlin_shift, xlin_dbus  out  1 each  X input muxes
fout  out  1  next flag value
halted  out  1  state==HALT
bus_err  out  1  sticky wait-timeout error

Behaviour:
- Reset: state=HALT, phase=0, bit_cnt=0, wait counter=0, bus_err=0, edge-detect registers=0. All write strobes are 0 while rst=1 and on the first cycle after release.
- ws (internal) = (phase==1) in FETCH/LOAD/DEREF/EXEC; ws=1 on every ALU cycle; ws=0 in HALT.
- Setup phase (FETCH/LOAD/DEREF/EXEC): hold phase=0 until mem_ready=1, then phase=1 on the next edge. The write phase always lasts exactly one cycle, then the state advances with phase=0.
- Wait timeout: wait counter increments each phase-0 cycle with mem_ready=0. On reaching WAIT_LIMIT (if nonzero): bus_err=1, go to HALT with no strobe issued. A new wait resets the counter.
- Transitions at end of write phase: FETCH->LOAD if op5=0, else EXEC. LOAD->DEREF if op2=1, else EXEC. DEREF->EXEC. EXEC->ALU if alu_class=((~op3&~op4)|~op5), else boundary.
- ALU: one bit per cycle, no wait states, bit_cnt 0..WIDTH-1. At bit_cnt=WIDTH-1: bit_cnt=0, then boundary.
- Boundary: FETCH if run=1; otherwise HALT.
- HALT: run=1 -> FETCH, and bus_err is cleared. A step rising edge -> FETCH for exactly one instruction (internal one-shot), and bus_err is cleared. run and step are ignored outside HALT until the next boundary.
- dep_sw rising edge in HALT asserts wrm=1 and incp_clk=1 for exactly one cycle. dep_sw is ignored outside HALT.
- Decode (FE/LD/DR/EX/AL = state is FETCH/LOAD/DEREF/EXEC/ALU):
  - rdp=FE; rdx=~FE; rda=EX; rdm=~EX.
  - wro=FE&ws; wra=AL&ws; wrx=(AL|DR|LD|FE)&ws; wrp=EX&op5&op4&(~op3|~f)&ws.
  - incp_clk=FE&ws | deposit pulse; wrm=EX&op5&~op4&op3&ws | deposit pulse; wrf=(AL|EX&~op5)&ws.
  - xhin_shift=xlin_shift=AL; xhin_p=FE&~dbus_msb; xhin_zero=FE&dbus_msb; xhin_dbus=LD|DR; xlin_dbus=~AL.
  - fout=(AL&alu_cout)|(EX&(~op4|(op3&x0))).
- Asynchronous reset asserted mid-instruction aborts the instruction immediately to the reset state. No strobe may glitch high on the reset edge.

Test Plan:
- Reset then run=1, op=0000 (ld, ALU class), mem_ready=1 -> states FETCH(2)->LOAD(2)->EXEC(2)->ALU(8)->FETCH. wro, wrx, incp_clk each pulse 1 cycle in FETCH write phase; wra high for 8 cycles.
- Jump op=1100 (op5,op4 set, op3=0), run=1 -> FETCH->EXEC->FETCH, wrp=1 exactly one cycle. Repeat with op=1110, f=1 -> wrp stays 0.
- mem_ready low 3 cycles in LOAD setup -> phase held 0 for 3 extra cycles, no strobes. Low for 16 cycles with WAIT_LIMIT=15 -> bus_err=1, HALT, no wrx pulse.
- run=0 in HALT, one step pulse -> exactly one instruction executes, then halted=1. A second step pulse mid-instruction has no effect.
- In HALT, dep_sw held high 5 cycles -> wrm and incp_clk each high exactly 1 cycle.
- Assert rst during ALU bit 4 -> state=HALT, bit_cnt=0, all strobes 0 immediately, without waiting for a clock edge.
